// File: rtl/lfsr_stevej.sv
// lfsr_stevej: free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// with a byte-wise host-loadable seed and a selectable output byte.
module lfsr_stevej (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] SEED_RST = 16'hACE1;

  logic        run;
  logic        load_lo;
  logic        load_hi;
  logic        sel_hi;
  logic        fb;
  logic        unused_ui;
  logic [15:0] s_d;
  logic [15:0] s_q;

  assign run       = ui_in[0];
  assign load_lo   = ui_in[1];
  assign load_hi   = ui_in[2];
  assign sel_hi    = ui_in[3];
  assign unused_ui = &{1'b0, ui_in[7:4]};

  assign fb = s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10];

  // Next state: loads take priority over stepping; all-zero state escapes to 1.
  always_comb begin
    s_d = s_q;
    if (ena) begin
      if (load_lo || load_hi) begin
        if (load_lo) s_d[7:0]  = uio_in;
        if (load_hi) s_d[15:8] = uio_in;
      end else if (run) begin
        if (s_q == '0) s_d = 16'h0001;
        else           s_d = {s_q[14:0], fb};
      end
    end
  end

  // State register with asynchronous reset to the fixed seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= SEED_RST;
    else     s_q <= s_d;
  end

  // Output byte select straight off the state register.
  always_comb begin
    uo_out = sel_hi ? s_q[15:8] : s_q[7:0];
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_lfsr_stevej.sv
// tb_lfsr_stevej: directed checks of reset, stepping, loads, priority,
// lock-up escape, enable, async reset and full period.
module tb_lfsr_stevej;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  lfsr_stevej dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance past the next rising edge by 1ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read full 16-bit state through the output mux; leaves sel_hi at 0.
  task automatic read_state(output logic [15:0] s);
    ui_in[3] = 1'b0;
    #1;
    s[7:0] = uo_out;
    ui_in[3] = 1'b1;
    #1;
    s[15:8] = uo_out;
    ui_in[3] = 1'b0;
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] s);
    if (s == 16'h0000) return 16'h0001;
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] st;
  logic [15:0] m;
  int unsigned mism;
  int unsigned first_ret;

  initial begin
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #2;
    // Reset state visible during reset
    check("rst_lo", uo_out, 8'hE1);
    ui_in[3] = 1'b1; #1;
    check("rst_hi", uo_out, 8'hAC);
    ui_in[3] = 1'b0;
    check("uio_oe_rst", uio_oe, 8'h00);
    check("uio_out_rst", uio_out, 8'h00);
    tick();
    rst = 1'b0;

    // Idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_lo", uo_out, 8'hE1);
    end
    read_state(st);
    check("idle_state", st, 16'hACE1);

    // Two steps from reset seed
    ui_in = 8'h01;
    tick();
    check("step1_lo", uo_out, 8'hC3);
    ui_in[3] = 1'b1; #1;
    check("step1_hi", uo_out, 8'h59);
    ui_in[3] = 1'b0;
    tick();
    check("step2_lo", uo_out, 8'h87);
    ui_in[3] = 1'b1; #1;
    check("step2_hi", uo_out, 8'hB3);
    ui_in = 8'h00;

    // Loads beat run
    uio_in = 8'h00; ui_in = 8'h05;
    tick(); read_state(st);
    check("load_hi_run", st, 16'h0087);
    uio_in = 8'h01; ui_in = 8'h03;
    tick(); read_state(st);
    check("load_lo_run", st, 16'h0001);
    ui_in = 8'h01;
    tick(); read_state(st);
    check("step_from1", st, 16'h0002);
    tick(); read_state(st);
    check("step_from2", st, 16'h0004);
    uio_in = 8'h5A; ui_in = 8'h06;
    tick(); read_state(st);
    check("load_both", st, 16'h5A5A);

    // Zero lock-up escape
    uio_in = 8'h00; ui_in = 8'h06;
    tick(); ui_in = 8'h00; read_state(st);
    check("load_zero", st, 16'h0000);
    for (int i = 0; i < 3; i++) tick();
    read_state(st);
    check("zero_hold", st, 16'h0000);
    ui_in = 8'h01;
    tick(); ui_in = 8'h00; read_state(st);
    check("zero_escape", st, 16'h0001);

    // Enable low freezes steps and loads
    ena = 1'b0; ui_in = 8'h01;
    tick(); read_state(st);
    check("ena0_run", st, 16'h0001);
    uio_in = 8'h33; ui_in = 8'h02;
    tick(); read_state(st);
    check("ena0_load", st, 16'h0001);
    ena = 1'b1; ui_in = 8'h00;
    check("uio_oe_mid", uio_oe, 8'h00);
    check("uio_out_mid", uio_out, 8'h00);

    // Async reset between edges while running
    ui_in = 8'h01;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_lo", uo_out, 8'hE1);
    ui_in = 8'h00;
    tick();
    rst = 1'b0;
    read_state(st);
    check("after_rst", st, 16'hACE1);

    // Full period against a software model
    mism = 0; first_ret = 0; m = 16'hACE1;
    ui_in = 8'h01;
    for (int unsigned i = 1; i <= 65535; i++) begin
      tick();
      read_state(st);
      m = model_next(m);
      if (st !== m) mism++;
      if (first_ret == 0 && st == 16'hACE1) first_ret = i;
    end
    ui_in = 8'h00;
    check("period_mismatches", mism, 0);
    check("period_first_return", first_ret, 65535);
    check("period_end_state", st, 16'hACE1);
    check("uio_oe_end", uio_oe, 8'h00);
    check("uio_out_end", uio_out, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
